// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared IEEE-754 single-precision constants, types and helpers
//
// Purpose : field layout, special encodings and the leading-zero counter
//           used by the ALU top and its rounding/packing stage.
// Ports   : none (package)
package alu_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_sel_e;

  // Number of zeros above the highest set bit; 47 for an all-zero input.
  function automatic logic [5:0] clz47(input logic [46:0] v);
    logic [5:0] n;
    n = 6'd47;
    for (int i = 0; i < 47; i++) begin
      if (v[i]) n = 6'(46 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_fp_round_pack.sv
// rtl/alu_fp_round_pack.sv - normalise, round-to-nearest-even and pack an FP32 result
//
// Purpose : takes an unrounded significand frame and produces the packed
//           single-precision word, handling rounding carry, overflow to
//           infinity and flush-to-zero on underflow.
// Ports   : sign_i    result sign
//           exp_i     signed biased exponent of frame bit 46
//           sig_i     48-bit significand frame; bit 47 is a carry-out position,
//                     bits below 23 are guard/round/sticky material
//           result_o  packed IEEE-754 single result
module alu_fp_round_pack
  import alu_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [9:0]  exp_i,
  input  logic        [47:0] sig_i,
  output logic        [31:0] result_o
);

  logic        [5:0]  lz;
  logic        [46:0] norm;
  logic               sticky_x;
  logic signed [9:0]  e_norm;
  logic        [23:0] mant;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic        [24:0] mant_r;
  logic signed [9:0]  e_r;
  logic        [22:0] frac;

  always_comb begin
    lz       = clz47(sig_i[46:0]);
    norm     = '0;
    sticky_x = 1'b0;
    e_norm   = exp_i;
    if (sig_i[47]) begin
      // Carry-out: shift right once, the dropped bit joins the sticky.
      norm     = sig_i[47:1];
      sticky_x = sig_i[0];
      e_norm   = exp_i + 10'sd1;
    end else begin
      norm   = sig_i[46:0] << lz;
      e_norm = exp_i - $signed({4'b0000, lz});
    end
  end

  assign mant     = norm[46:23];
  assign guard    = norm[22];
  assign sticky   = (|norm[21:0]) | sticky_x;
  assign round_up = guard & (sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + {24'b0, round_up};
  // A rounding carry leaves mant_r = 1_0000..., i.e. fraction zero, exponent + 1.
  assign e_r      = e_norm + $signed({9'b0, mant_r[24]});
  assign frac     = mant_r[23] ? mant_r[22:0] : 23'b0;

  always_comb begin
    result_o = {sign_i, e_r[7:0], frac};
    if (sig_i == '0) begin
      result_o = {sign_i, 31'b0};
    end else if (e_r >= 10'sd255) begin
      result_o = {sign_i, EXP_MAX, 23'b0};
    end else if (e_r <= 10'sd0) begin
      result_o = {sign_i, 31'b0};
    end
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered IEEE-754 single-precision add/multiply ALU
//
// Purpose : computes A+B and A*B in parallel, selects one and registers it
//           together with a flag marking infinite/NaN results.
// Ports   : clk       rising-edge clock
//           rst_n     asynchronous active-low reset
//           A, B      IEEE-754 single operands
//           selector  0 = add, 1 = multiply
//           Result    registered result
//           carry     registered flag, 1 when Result is +/-inf or NaN
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        selector,
  output logic [31:0] Result,
  output logic        carry
);

  fp32_t a, b;
  assign a = A;
  assign b = B;

  // Denormals count as zero.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);
  assign a_inf  = (a.exp == EXP_MAX) && (a.frac == '0);
  assign b_inf  = (b.exp == EXP_MAX) && (b.frac == '0);
  assign a_nan  = (a.exp == EXP_MAX) && (a.frac != '0);
  assign b_nan  = (b.exp == EXP_MAX) && (b.frac != '0);

  // ---------------- add path ----------------
  // Order by magnitude so the subtraction below never goes negative.
  logic        swap;
  fp32_t       hi_op, lo_op;
  logic [7:0]  exp_diff;
  logic [47:0] hi_sig, lo_sig, shift_mask, lo_shift, add_sig;
  logic        add_sign;
  logic signed [9:0] add_exp;
  logic [31:0] add_rp, add_res;

  assign swap     = (B[30:0] > A[30:0]);
  assign hi_op    = swap ? b : a;
  assign lo_op    = swap ? a : b;
  assign exp_diff = hi_op.exp - lo_op.exp;
  assign hi_sig   = {2'b01, hi_op.frac, 23'b0};
  assign lo_sig   = {2'b01, lo_op.frac, 23'b0};
  // Bits shifted out below the frame are jammed into bit 0 as sticky.
  assign shift_mask = (48'h1 << exp_diff) - 48'h1;
  assign lo_shift   = (lo_sig >> exp_diff) | {47'b0, |(lo_sig & shift_mask)};
  assign add_sig    = (a.sign ^ b.sign) ? (hi_sig - lo_shift) : (hi_sig + lo_shift);
  // Exact cancellation yields +0.
  assign add_sign   = (add_sig == '0) ? 1'b0 : hi_op.sign;
  assign add_exp    = $signed({2'b00, hi_op.exp});

  alu_fp_round_pack u_add_rp (
    .sign_i   (add_sign),
    .exp_i    (add_exp),
    .sig_i    (add_sig),
    .result_o (add_rp)
  );

  always_comb begin
    add_res = add_rp;
    if (a_nan || b_nan)          add_res = QNAN;
    else if (a_inf && b_inf)     add_res = (a.sign == b.sign) ? A : QNAN;
    else if (a_inf)              add_res = A;
    else if (b_inf)              add_res = B;
    else if (a_zero && b_zero)   add_res = {a.sign & b.sign, 31'b0};
    else if (a_zero)             add_res = B;
    else if (b_zero)             add_res = A;
  end

  // ---------------- mul path ----------------
  logic [47:0] mul_sig;
  logic        mul_sign;
  logic signed [9:0] mul_exp;
  logic [31:0] mul_rp, mul_res;

  assign mul_sign = a.sign ^ b.sign;
  assign mul_sig  = {24'b0, 1'b1, a.frac} * {24'b0, 1'b1, b.frac};
  // Product bit 46 carries weight 2^(eA+eB-2*BIAS), i.e. biased eA+eB-BIAS.
  assign mul_exp  = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - $signed(10'(BIAS));

  alu_fp_round_pack u_mul_rp (
    .sign_i   (mul_sign),
    .exp_i    (mul_exp),
    .sig_i    (mul_sig),
    .result_o (mul_rp)
  );

  always_comb begin
    mul_res = mul_rp;
    if (a_nan || b_nan)                             mul_res = QNAN;
    else if ((a_inf && b_zero) || (a_zero && b_inf)) mul_res = QNAN;
    else if (a_inf || b_inf)                        mul_res = POS_INF | {mul_sign, 31'b0};
    else if (a_zero || b_zero)                      mul_res = {mul_sign, 31'b0};
  end

  // ---------------- output register ----------------
  logic [31:0] result_d, result_q;
  logic        carry_d, carry_q;

  assign result_d = (selector == OP_MUL) ? mul_res : add_res;
  assign carry_d  = (result_d[30:23] == EXP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign Result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for the FP32 add/multiply ALU
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic        selector;
  logic [31:0] Result;
  logic        carry;

  int n_tests = 0;
  int n_fail  = 0;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .selector (selector),
    .Result   (Result),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // Reference: operands widened to double, operation done in double, then
  // rounded to single with RNE, overflow to inf and flush-to-zero.
  function automatic real f32_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'b0};
    else                        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    logic        g, st;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) return (d[51:0] != 52'b0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'b0};
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    e  = int'(d[62:52]) - 1023 + 127;
    m  = {2'b01, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0)   return {d[63], 31'b0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic sel);
    real ra, rb;
    ra = f32_to_real(a);
    rb = f32_to_real(b);
    return real_to_f32(sel ? ra * rb : ra + rb);
  endfunction

  logic [31:0] specials [11] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                 32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h807FFFFF,
                                 32'h7F7FFFFF, 32'h00800000, 32'h3F800000};

  function automatic logic [31:0] rand_base();
    case ($urandom_range(0, 7))
      0:       return specials[$urandom_range(0, 10)];
      1:       return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_partner(input logic [31:0] a);
    case ($urandom_range(0, 7))
      0:       return specials[$urandom_range(0, 10)];
      1:       return {~a[31], a[30:3], 3'($urandom)};
      2:       return {1'($urandom), a[30:23] + 8'($urandom_range(0, 30)), 23'($urandom)};
      3:       return {~a[31], a[30:0]};
      default: return rand_base();
    endcase
  endfunction

  // One op per clock; each call checks the op issued on the previous call.
  logic [31:0] want_res;
  logic        want_carry;
  logic        pend = 1'b0;
  string       pend_tag;

  task automatic check_pending();
    if (pend) begin
      check_eq({pend_tag, ".res"}, Result, want_res);
      check_eq({pend_tag, ".carry"}, {31'b0, carry}, {31'b0, want_carry});
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic sel,
                      input logic [31:0] want, input string tag);
    @(posedge clk);
    #1;
    check_pending();
    A          = a;
    B          = b;
    selector   = sel;
    want_res   = want;
    want_carry = (want[30:23] == 8'hFF);
    pend_tag   = tag;
    pend       = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    check_pending();
    pend = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb, rt;
    logic        rs;

    rst_n    = 1'b0;
    A        = 32'h7F800000;
    B        = 32'h7F800000;
    selector = 1'b0;
    #12;
    check_eq("reset.res", Result, 32'h0);
    check_eq("reset.carry", {31'b0, carry}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("reset_hold.res", Result, 32'h0);
    #3 rst_n = 1'b1;

    step(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "add_1p2");
    step(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, "add_cancel");
    step(32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, "mul_1x2");
    step(32'h3F800000, 32'hBF800000, 1'b1, 32'hBF800000, "mul_1xm1");
    step(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, "add_zero");
    step(32'h3F800000, 32'h00000000, 1'b1, 32'h00000000, "mul_zero");
    step(32'h4F000000, 32'h4E800000, 1'b0, 32'h4F400000, "add_big");
    step(32'h4F000000, 32'h4E800000, 1'b1, 32'h5E000000, "mul_big");
    step(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, "add_inf");
    step(32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, "mul_inf");
    step(32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000, "mul_ovf");
    step(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, "mul_inf_zero");
    step(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, "add_inf_minf");
    step(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, "add_nan");
    step(32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, "mul_denorm");
    step(32'h00800000, 32'h00800000, 1'b1, 32'h00000000, "mul_uflow");
    step(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, "add_tie_even");
    step(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, "add_tie_odd");
    step(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, "add_rnd_carry");
    step(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "add_ovf");
    step(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, "add_mzero");

    for (int i = 0; i < 4000; i++) begin
      ra = rand_base();
      rb = rand_partner(ra);
      if ($urandom_range(0, 1) == 1) begin
        rt = ra;
        ra = rb;
        rb = rt;
      end
      rs = 1'($urandom);
      step(ra, rb, rs, ref_alu(ra, rb, rs), rs ? "rand_mul" : "rand_add");
    end
    drain();

    // Asynchronous reset in the middle of a stream.
    A        = 32'h7F800000;
    B        = 32'h7F800000;
    selector = 1'b0;
    @(posedge clk);
    #1;
    check_eq("pre_rst.res", Result, 32'h7F800000);
    check_eq("pre_rst.carry", {31'b0, carry}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst.res", Result, 32'h0);
    check_eq("async_rst.carry", {31'b0, carry}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_edge.res", Result, 32'h0);
    #2 rst_n = 1'b1;
    #1;
    check_eq("rel_no_edge.res", Result, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rel_first.res", Result, 32'h7F800000);
    check_eq("rel_first.carry", {31'b0, carry}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
